// File: rtl/game_turn_if.sv
// game_turn_if: dice input, renderer handshake and position outputs of the turn controller.
interface game_turn_if;
  logic [2:0] dice_value;
  logic       dice_valid;
  logic       turn_done;
  logic [9:0] player1_pos_x;
  logic [9:0] player2_pos_x;
  logic       pos_valid;
  logic       active_player;
  logic       winner_valid;
  logic       winner_id;
  logic       busy;
  modport master (
    output dice_value, dice_valid, turn_done,
    input  player1_pos_x, player2_pos_x, pos_valid, active_player, winner_valid, winner_id, busy
  );
  modport slave (
    input  dice_value, dice_valid, turn_done,
    output player1_pos_x, player2_pos_x, pos_valid, active_player, winner_valid, winner_id, busy
  );
endinterface

// File: rtl/game_turn_ctrl.sv
// game_turn_ctrl: two-player dice race controller; advances the active player and handshakes with the renderer.
module game_turn_ctrl #(
  parameter int TILE_X0     = 20,
  parameter int TILE_PITCH  = 60,
  parameter int FINISH_TILE = 10,
  parameter int TIMEOUT_CYC = 25_000_000
) (
  input logic         clk,
  input logic         rst,
  game_turn_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT_CYC);
  typedef enum logic [2:0] {IDLE, MOVE, WAIT, CHECK, WIN} state_t;
  state_t          r_state, w_next;
  logic [2:0]      r_roll;
  logic [3:0]      r_tile1, r_tile2;
  logic [9:0]      r_p1x, r_p2x;
  logic            r_pos_valid, r_active, r_winner_valid, r_winner_id;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      w_cur_tile, w_new_tile;
  logic [4:0]      w_sum;
  logic            w_bonus, w_win, w_legal, w_timeout;
  function automatic logic [9:0] tile_x(input logic [3:0] t);
    logic [15:0] x;
    x = 16'(TILE_X0) + 16'(t) * 16'(TILE_PITCH);
    return x[9:0];
  endfunction
  always_comb begin
    w_cur_tile = r_active ? r_tile2 : r_tile1;
    w_sum      = {1'b0, w_cur_tile} + {2'b0, r_roll};
    w_new_tile = (w_sum >= 5'(FINISH_TILE)) ? 4'(FINISH_TILE) : w_sum[3:0];
    w_win      = w_cur_tile == 4'(FINISH_TILE);
    w_bonus    = (w_cur_tile == 4'd2) || (w_cur_tile == 4'd4) || (w_cur_tile == 4'd6) || (w_cur_tile == 4'd8);
    w_legal    = bus.dice_valid && bus.dice_value != 3'd0 && bus.dice_value != 3'd7;
    w_timeout  = r_cnt == CW'(TIMEOUT_CYC - 1);
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_legal ? MOVE : IDLE;
      MOVE:    w_next = WAIT;
      WAIT:    w_next = (bus.turn_done || w_timeout) ? CHECK : WAIT;
      CHECK:   w_next = w_win ? WIN : IDLE;
      default: w_next = WIN;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_roll         <= 3'd0;
      r_tile1        <= 4'd0;
      r_tile2        <= 4'd0;
      r_p1x          <= tile_x(4'd0);
      r_p2x          <= tile_x(4'd0);
      r_pos_valid    <= 1'b0;
      r_active       <= 1'b0;
      r_winner_valid <= 1'b0;
      r_winner_id    <= 1'b0;
      r_cnt          <= '0;
    end else begin
      r_state     <= w_next;
      r_pos_valid <= r_state == MOVE;
      if (r_state == IDLE && w_legal) r_roll <= bus.dice_value;
      if (r_state == MOVE) begin
        r_cnt <= '0;
        if (r_active) begin
          r_tile2 <= w_new_tile;
          r_p2x   <= tile_x(w_new_tile);
        end else begin
          r_tile1 <= w_new_tile;
          r_p1x   <= tile_x(w_new_tile);
        end
      end
      if (r_state == WAIT) r_cnt <= r_cnt + 1'b1;
      // question-box tiles grant the same player another roll
      if (r_state == CHECK) begin
        if (w_win) begin
          r_winner_valid <= 1'b1;
          r_winner_id    <= r_active;
        end else if (!w_bonus) r_active <= ~r_active;
      end
    end
  end
  assign bus.player1_pos_x = r_p1x;
  assign bus.player2_pos_x = r_p2x;
  assign bus.pos_valid     = r_pos_valid;
  assign bus.active_player = r_active;
  assign bus.winner_valid  = r_winner_valid;
  assign bus.winner_id     = r_winner_id;
  assign bus.busy          = r_state != IDLE;
endmodule

// File: tb/tb_game_turn_ctrl.sv
// tb_game_turn_ctrl: directed turns with a pos_valid scoreboard plus handshake/timing checks.
module tb_game_turn_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  game_turn_if bus();
  game_turn_ctrl #(.TIMEOUT_CYC(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [9:0] p1;
    logic [9:0] p2;
    logic       act;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst && bus.pos_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pos_valid: got 1 expected 0 at %0t", $time);
      end else begin
        mon_e = q.pop_front();
        chk("pos_p1x", int'(bus.player1_pos_x), int'(mon_e.p1));
        chk("pos_p2x", int'(bus.player2_pos_x), int'(mon_e.p2));
        chk("pos_active", int'(bus.active_player), int'(mon_e.act));
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic reset_chk(input string n);
    chk({n, "_p1x"}, int'(bus.player1_pos_x), 20);
    chk({n, "_p2x"}, int'(bus.player2_pos_x), 20);
    chk({n, "_pv"}, int'(bus.pos_valid), 0);
    chk({n, "_act"}, int'(bus.active_player), 0);
    chk({n, "_wv"}, int'(bus.winner_valid), 0);
    chk({n, "_wid"}, int'(bus.winner_id), 0);
    chk({n, "_busy"}, int'(bus.busy), 0);
  endtask
  task automatic roll(input logic [2:0] v, input int p1, input int p2, input int act);
    exp_t e;
    e.p1 = p1[9:0];
    e.p2 = p2[9:0];
    e.act = act[0];
    q.push_back(e);
    bus.dice_value = v;
    bus.dice_valid = 1'b1;
    step(1);
    bus.dice_valid = 1'b0;
    chk("move_busy", int'(bus.busy), 1);
    chk("move_no_pv", int'(bus.pos_valid), 0);
    step(1);
    chk("pv_latency", int'(bus.pos_valid), 1);
  endtask
  task automatic done(input int act, input int wv, input int wid, input int busy);
    bus.turn_done = 1'b1;
    step(1);
    bus.turn_done = 1'b0;
    chk("check_busy", int'(bus.busy), 1);
    step(1);
    chk("done_act", int'(bus.active_player), act);
    chk("done_wv", int'(bus.winner_valid), wv);
    chk("done_wid", int'(bus.winner_id), wid);
    chk("done_busy", int'(bus.busy), busy);
  endtask
  initial begin
    bus.dice_value = 3'd0;
    bus.dice_valid = 1'b0;
    bus.turn_done  = 1'b0;
    step(3);
    reset_chk("reset");
    rst = 1'b1;
    step(2);
    for (int i = 0; i < 2; i++) begin
      bus.dice_value = (i == 0) ? 3'd0 : 3'd7;
      bus.dice_valid = 1'b1;
      step(1);
      bus.dice_valid = 1'b0;
      chk("illegal_busy", int'(bus.busy), 0);
      step(2);
      chk("illegal_busy2", int'(bus.busy), 0);
    end
    roll(3'd3, 200, 20, 0);
    step(3);
    done(1, 0, 0, 0);
    chk("p2_untouched", int'(bus.player2_pos_x), 20);
    roll(3'd2, 200, 140, 1);
    step(2);
    done(1, 0, 0, 0);
    roll(3'd2, 200, 260, 1);
    step(2);
    bus.dice_value = 3'd3;
    bus.dice_valid = 1'b1;
    step(1);
    bus.dice_valid = 1'b0;
    chk("drop_busy", int'(bus.busy), 1);
    step(2);
    done(1, 0, 0, 0);
    chk("drop_p2x", int'(bus.player2_pos_x), 260);
    roll(3'd1, 200, 320, 1);
    step(3);
    done(0, 0, 0, 0);
    roll(3'd2, 320, 320, 0);
    step(15);
    chk("to_wait_busy", int'(bus.busy), 1);
    chk("to_wait_act", int'(bus.active_player), 0);
    step(1);
    chk("to_check_busy", int'(bus.busy), 1);
    chk("to_check_act", int'(bus.active_player), 0);
    step(1);
    chk("to_idle_act", int'(bus.active_player), 1);
    chk("to_idle_busy", int'(bus.busy), 0);
    roll(3'd3, 320, 500, 1);
    done(1, 0, 0, 0);
    roll(3'd6, 320, 620, 1);
    step(2);
    done(1, 1, 1, 1);
    bus.dice_value = 3'd4;
    bus.dice_valid = 1'b1;
    step(1);
    bus.dice_valid = 1'b0;
    step(4);
    bus.turn_done = 1'b1;
    step(1);
    bus.turn_done = 1'b0;
    step(3);
    chk("win_busy", int'(bus.busy), 1);
    chk("win_wv", int'(bus.winner_valid), 1);
    chk("win_wid", int'(bus.winner_id), 1);
    chk("win_p1x", int'(bus.player1_pos_x), 320);
    chk("win_p2x", int'(bus.player2_pos_x), 620);
    rst = 1'b0;
    #1;
    reset_chk("rst_win");
    step(2);
    rst = 1'b1;
    step(3);
    roll(3'd3, 200, 20, 0);
    step(2);
    rst = 1'b0;
    #1;
    reset_chk("rst_wait");
    step(1);
    rst = 1'b1;
    step(3);
    chk("release_busy", int'(bus.busy), 0);
    roll(3'd1, 80, 20, 0);
    step(3);
    done(1, 0, 0, 0);
    step(5);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
